// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, memory
// write_length codes and the request FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Offset of the last byte touched by an access of the given length.
  function automatic logic [1:0] last_byte_offset(input logic [1:0] len);
    case (len)
      LEN_BYTE: last_byte_offset = 2'd0;
      LEN_HALF: last_byte_offset = 2'd1;
      default:  last_byte_offset = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: funct3 length decode, MSB-justified
// store placement and big-endian load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [31:0] rd_data_i,
  output logic [1:0]  len_o,
  output logic        funct3_err_o,
  output logic [31:0] wr_placed_o,
  output logic [31:0] rd_ext_o
);

  // Unsigned variants only exist for loads, so they are illegal on stores.
  always_comb begin
    len_o        = LEN_WORD;
    funct3_err_o = 1'b0;
    case (req_funct3_i)
      F3_B:    len_o = LEN_BYTE;
      F3_H:    len_o = LEN_HALF;
      F3_W:    len_o = LEN_WORD;
      F3_BU: begin
        len_o        = LEN_BYTE;
        funct3_err_o = req_store_i;
      end
      F3_HU: begin
        len_o        = LEN_HALF;
        funct3_err_o = req_store_i;
      end
      default: funct3_err_o = 1'b1;
    endcase
  end

  always_comb begin
    wr_placed_o = req_wdata_i;
    case (len_o)
      LEN_BYTE: wr_placed_o = {req_wdata_i[7:0], 24'h0};
      LEN_HALF: wr_placed_o = {req_wdata_i[15:0], 16'h0};
      default:  wr_placed_o = req_wdata_i;
    endcase
  end

  // The memory returns the addressed byte in the top lane.
  always_comb begin
    rd_ext_o = rd_data_i;
    case (ld_funct3_i)
      F3_B:    rd_ext_o = {{24{rd_data_i[31]}}, rd_data_i[31:24]};
      F3_BU:   rd_ext_o = {24'h0, rd_data_i[31:24]};
      F3_H:    rd_ext_o = {{16{rd_data_i[31]}}, rd_data_i[31:16]};
      F3_HU:   rd_ext_o = {16'h0, rd_data_i[31:16]};
      default: rd_ext_o = rd_data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a byte-addressed big-endian memory port.
// One request per three cycles: IDLE accepts, ACCESS touches memory, RESP answers.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 5096,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_write_length,
  output logic        mem_wr_enable,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  len_q, len_d;
  logic        store_q, store_d;
  logic        err_q, err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  req_len;
  logic        funct3_err;
  logic [31:0] wr_placed;
  logic [31:0] rd_ext;
  logic [32:0] last_byte;
  logic        range_err;
  logic        align_err;

  lsu_align u_align (
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_wdata_i  (req_wdata),
    .ld_funct3_i  (funct3_q),
    .rd_data_i    (mem_read_data),
    .len_o        (req_len),
    .funct3_err_o (funct3_err),
    .wr_placed_o  (wr_placed),
    .rd_ext_o     (rd_ext)
  );

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign last_byte = {1'b0, req_addr} + {31'b0, last_byte_offset(req_len)};
  assign range_err = (last_byte >= 33'(MEM_BYTES));
  assign align_err = CHECK_ALIGN &&
                     (((req_len == LEN_HALF) && req_addr[0]) ||
                      ((req_len == LEN_WORD) && (req_addr[1:0] != 2'b00)));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    len_d    = len_q;
    store_d  = store_q;
    err_d    = err_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = wr_placed;
          len_d    = req_len;
          store_d  = req_store;
          err_d    = funct3_err | range_err | align_err;
          funct3_d = req_funct3;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = (!store_q && !err_q) ? rd_ext : 32'h0;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      len_q    <= LEN_BYTE;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b000;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      len_q    <= len_d;
      store_q  <= store_d;
      err_q    <= err_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
    end
  end

  // Strobe decoded from state so that reset removes it immediately.
  assign req_ready        = (state_q == ST_IDLE);
  assign mem_wr_enable    = (state_q == ST_ACCESS) && store_q && !err_q;
  assign resp_valid       = (state_q == ST_RESP);
  assign resp_err         = resp_valid && err_q;
  assign resp_rdata       = resp_valid ? rdata_q : 32'h0;
  assign mem_address      = addr_q;
  assign mem_wr_data      = wdata_q;
  assign mem_write_length = len_q;

endmodule
